// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: replays solved moves as two motion
// commands each, or passes UART commands through when no tour is active.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);
  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  typedef enum logic [2:0] {
    IDLE, HORZ, HWAIT, VERT, VWAIT
  } state_t;

  state_t      r_state;
  logic [4:0]  r_indx;
  logic        r_rdy;
  logic        r_active;
  logic        r_vleg;

  logic [7:0]  w_hhd;
  logic [7:0]  w_vhd;
  logic [3:0]  w_hsq;
  logic [3:0]  w_vsq;
  logic [15:0] w_tour_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_indx   <= '0;
      r_rdy    <= 1'b0;
      r_active <= 1'b0;
      r_vleg   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_tour) begin
          r_state  <= HORZ;
          r_indx   <= '0;
          r_rdy    <= 1'b1;
          r_active <= 1'b1;
          r_vleg   <= 1'b0;
        end
        HORZ: if (clr_cmd_rdy) begin
          r_state <= HWAIT;
          r_rdy   <= 1'b0;
        end
        HWAIT: if (send_resp) begin
          r_state <= VERT;
          r_rdy   <= 1'b1;
          r_vleg  <= 1'b1;
        end
        VERT: if (clr_cmd_rdy) begin
          r_state <= VWAIT;
          r_rdy   <= 1'b0;
        end
        VWAIT: if (send_resp) begin
          r_vleg <= 1'b0;
          if (r_indx == LAST) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end else begin
            r_state <= HORZ;
            r_indx  <= r_indx + 5'd1;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rdy    <= 1'b0;
          r_active <= 1'b0;
          r_vleg   <= 1'b0;
        end
      endcase
    end
  end

  // Lowest set bit wins on a malformed move code.
  always_comb begin
    w_hhd = HD_N;
    w_hsq = 4'd0;
    w_vhd = HD_N;
    w_vsq = 4'd0;
    priority case (1'b1)
      move[0]: begin
        w_hhd = HD_W; w_hsq = 4'd1;
        w_vhd = HD_N; w_vsq = 4'd2;
      end
      move[1]: begin
        w_hhd = HD_E; w_hsq = 4'd1;
        w_vhd = HD_N; w_vsq = 4'd2;
      end
      move[2]: begin
        w_hhd = HD_W; w_hsq = 4'd2;
        w_vhd = HD_N; w_vsq = 4'd1;
      end
      move[3]: begin
        w_hhd = HD_W; w_hsq = 4'd2;
        w_vhd = HD_S; w_vsq = 4'd1;
      end
      move[4]: begin
        w_hhd = HD_W; w_hsq = 4'd1;
        w_vhd = HD_S; w_vsq = 4'd2;
      end
      move[5]: begin
        w_hhd = HD_E; w_hsq = 4'd1;
        w_vhd = HD_S; w_vsq = 4'd2;
      end
      move[6]: begin
        w_hhd = HD_E; w_hsq = 4'd2;
        w_vhd = HD_S; w_vsq = 4'd1;
      end
      move[7]: begin
        w_hhd = HD_E; w_hsq = 4'd2;
        w_vhd = HD_N; w_vsq = 4'd1;
      end
      default: ;
    endcase
  end

  assign w_tour_cmd = r_vleg ? {4'h3, w_vhd, w_vsq}
                             : {4'h2, w_hhd, w_hsq};

  assign cmd     = r_active ? w_tour_cmd : cmd_UART;
  assign cmd_rdy = r_active ? r_rdy : cmd_rdy_UART;
  assign resp    = r_active ? 8'h5A : 8'hA5;
  assign mv_indx = r_indx;

endmodule

// File: tb/tb_tour_cmd.sv
// Bench for tour_cmd: directed protocol walk with random move codes,
// expected commands derived from knight displacements.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;

  localparam int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  tour_cmd dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART),
    .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Knight displacement -> command: dx<0 west, dy>0 north.
  function automatic logic [15:0] ref_cmd(input logic [7:0] mv,
                                          input bit vleg);
    int b;
    int d;
    logic [7:0] hd;
    b = -1;
    for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
    if (b < 0) return vleg ? 16'h3000 : 16'h2000;
    if (!vleg) begin
      d  = DX[b];
      hd = (d < 0) ? 8'h3F : 8'hBF;
      return {4'h2, hd, 4'(d < 0 ? -d : d)};
    end
    d  = DY[b];
    hd = (d > 0) ? 8'h00 : 8'h7F;
    return {4'h3, hd, 4'(d < 0 ? -d : d)};
  endfunction

  function automatic logic [7:0] gen_move(input int i);
    int r;
    case (i)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h10;
      3: return 8'h40;
      default: ;
    endcase
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'($urandom_range(1, 255));
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_cmd"}, cmd, cmd_UART);
    chk({tag, "_rdy"}, 16'(cmd_rdy), 16'(cmd_rdy_UART));
    chk({tag, "_resp"}, 16'(resp), 16'h00A5);
  endtask

  initial begin
    logic [7:0] mv;
    rst = 1'b1; start_tour = 1'b0; move = 8'h00;
    cmd_UART = 16'h3FAE; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    idle_chk("reset");
    chk("reset_indx", 16'(mv_indx), 16'd0);
    cmd_rdy_UART = 1'b1;
    #1;
    idle_chk("idle_rdy1");
    cmd_UART = 16'h1234; send_resp = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    idle_chk("idle_noise");

    for (int i = 0; i < 24; i++) begin
      mv = gen_move(i);
      move = mv;
      if (i == 0) begin
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
      end
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'b1;
      #1;
      chk("h_rdy", 16'(cmd_rdy), 16'd1);
      chk("h_cmd", cmd, ref_cmd(mv, 1'b0));
      chk("h_indx", 16'(mv_indx), 16'(i));
      chk("h_resp", 16'(resp), 16'h005A);
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("h_ign_send", 16'(cmd_rdy), 16'd1);
      clr_cmd_rdy = 1'b1;
      tick();
      chk("hw_rdy", 16'(cmd_rdy), 16'd0);
      chk("hw_cmd", cmd, ref_cmd(mv, 1'b0));
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      chk("hw_ign", 16'(cmd_rdy), 16'd0);
      chk("hw_indx", 16'(mv_indx), 16'(i));
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0; clr_cmd_rdy = 1'b0;
      chk("v_rdy", 16'(cmd_rdy), 16'd1);
      chk("v_cmd", cmd, ref_cmd(mv, 1'b1));
      chk("v_indx", 16'(mv_indx), 16'(i));
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      chk("vw_rdy", 16'(cmd_rdy), 16'd0);
      chk("vw_cmd", cmd, ref_cmd(mv, 1'b1));
      send_resp = 1'b1;
      clr_cmd_rdy = 1'($urandom_range(0, 1));
      #1;
      chk("vw_resp", 16'(resp), 16'h005A);
      tick();
      send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    end
    idle_chk("done");
    chk("done_indx", 16'(mv_indx), 16'd23);
    cmd_rdy_UART = 1'b0;
    #1;
    chk("done_rdy0", 16'(cmd_rdy), 16'd0);

    move = 8'h08;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    chk("t2_indx", 16'(mv_indx), 16'd0);
    chk("t2_cmd", cmd, 16'h23F2);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("t2_adv", 16'(mv_indx), 16'd1);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("t2_vert", cmd, 16'h37F1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_chk("abort");
    chk("abort_indx", 16'(mv_indx), 16'd0);
    tick();
    idle_chk("abort_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Command sequencer between the knight's-tour solver and the motion command processor.
- When idle it passes UART commands straight through.
- After start_tour it replays the solved tour. Each knight move (one-hot move code at index mv_indx) is split into a horizontal move command followed by a vertical move-with-fanfare command.
- It handshakes each command with the downstream consumer via clr_cmd_rdy/send_resp, then returns control to UART after the last move.

Parameters:
NUM_MOVES, 24, number of knight moves in a tour; the last index is NUM_MOVES-1 (23).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start_tour  in  1  one-cycle pulse; begins tour replay from index 0
move  in  8  one-hot move code for index mv_indx, held stable by the solver
mv_indx  out  5  index of the move currently being issued
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  command-valid from UART wrapper
cmd  out  16  muxed command to the command processor
cmd_rdy  out  1  muxed command-valid
clr_cmd_rdy  in  1  consumer acknowledges / consumes the command
send_resp  in  1  consumer finished executing the command
resp  out  8  response byte: 8'h5A while touring, 8'hA5 otherwise

Behaviour:
- Reset: state IDLE, mv_indx=0. Outputs: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5. Reset mid-tour aborts immediately to IDLE.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Horizontal leg: opcode 4'h2.
  - Vertical leg: opcode 4'h3 (move with fanfare).
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit: horizontal leg / vertical leg):
  - bit0: W1 / N2
  - bit1: E1 / N2
  - bit2: W2 / N1
  - bit3: W2 / S1
  - bit4: W1 / S2
  - bit5: E1 / S2
  - bit6: E2 / S1
  - bit7: E2 / N1
  - Example: bit0 gives 16'h23F1 then 16'h3002.
  - Non-one-hot move: the lowest set bit wins.
  - move==0: both legs use heading 8'h00 with squares 0.
- Tour commands are decoded combinationally from move and the current state.
- FSM states and transitions:
  - IDLE: start_tour goes to HORZ with mv_indx<=0. start_tour is ignored in every other state.
  - HORZ: tour cmd_rdy=1, cmd=horizontal leg. clr_cmd_rdy goes to HWAIT.
  - HWAIT: cmd_rdy=0, cmd holds the horizontal leg. send_resp goes to VERT.
  - VERT: cmd_rdy=1, cmd=vertical leg. clr_cmd_rdy goes to VWAIT.
  - VWAIT: cmd_rdy=0, cmd holds the vertical leg. On send_resp:
    - if mv_indx==NUM_MOVES-1, go to IDLE;
    - otherwise mv_indx<=mv_indx+1 and go to HORZ.
- mv_indx changes only on start_tour (to 0), on the VWAIT advance, and on reset (to 0). It is constant across both legs of a move.
- Latencies:
  - cmd_rdy rises one cycle after start_tour.
  - cmd_rdy falls the edge after clr_cmd_rdy.
  - cmd_rdy re-rises the edge after send_resp. It is therefore a clean 0→1 edge per command.
- Output mux: tour active = (state != IDLE).
  - Active: cmd/cmd_rdy come from the FSM and UART inputs are ignored.
  - Idle: cmd=cmd_UART and cmd_rdy=cmd_rdy_UART, combinationally.
- resp = 8'h5A while active, 8'hA5 in IDLE.
  - After the final send_resp, resp reads 8'h5A in that cycle and 8'hA5 from the next cycle.
- Inputs outside the current state's expected event are ignored:
  - send_resp in HORZ/VERT;
  - clr_cmd_rdy in the WAIT states.
- A simultaneous clr_cmd_rdy and send_resp acts only on the one the current state expects.

Test Plan:
- Reset, then idle with cmd_UART=16'h3FAE → cmd=16'h3FAE, cmd_rdy follows cmd_rdy_UART, resp=8'hA5.
- start_tour with move=8'h01 → cmd_rdy rises with cmd=16'h23F1 and mv_indx=0. clr_cmd_rdy then send_resp → cmd=16'h3002, mv_indx=0.
- move=8'h02, send_resp → resp=8'h5A; next command 16'h2BF1 with mv_indx=1, then 16'h3002.
- move=8'h10 → 16'h23F1 then 16'h37F2, mv_indx=2. Also exercise move=8'h40 → 16'h2BF2 then 16'h37F1.
- Complete 24 moves → final send_resp gives resp 8'h5A that cycle and 8'hA5 the next; cmd/cmd_rdy then equal the UART inputs.
- Mid-tour rst, and start_tour pulsed mid-tour → rst returns to IDLE with mv_indx=0; start_tour mid-tour has no effect.
